// File: rtl/ysyx_22040632_bpu_if.sv
// ysyx_22040632_bpu_if: fetch-lookup and execute-update bus of the branch target buffer
interface ysyx_22040632_bpu_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 3,
  parameter int OCC_W = 4
);
  logic             flush_all;
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_target;
  logic             upd_taken;
  logic [OCC_W-1:0] occupancy;
  modport master (
    output flush_all, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken,
    input  pred_hit, pred_taken, pred_target, pred_idx, occupancy
  );
  modport slave (
    input  flush_all, lookup_pc, upd_valid, upd_pc, upd_target, upd_taken,
    output pred_hit, pred_taken, pred_target, pred_idx, occupancy
  );
endinterface

// File: rtl/ysyx_22040632_bpu.sv
// ysyx_22040632_bpu: fully associative BTB with saturating direction counters,
// fill-then-round-robin allocation of taken branches only.
module ysyx_22040632_bpu #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 rrst_n,
  ysyx_22040632_bpu_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES + 1);
  localparam int TAG_W = PC_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  logic [ENTRIES-1:0] valid_q, valid_d, hit_vec, upd_vec;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_d [ENTRIES];
  logic [IDX_W-1:0]   victim_q, victim_d, hit_idx, upd_idx, free_idx, alloc_idx;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [PC_W-1:0]    hit_target;
  logic               hit_msb, upd_hit, full;
  logic               unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};
  // Scanning high to low leaves the lowest invalid index in free_idx.
  always_comb begin
    hit_vec    = '0;
    upd_vec    = '0;
    hit_idx    = '0;
    upd_idx    = '0;
    free_idx   = '0;
    hit_target = '0;
    hit_msb    = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit_vec[i] = valid_q[i] && tag_q[i] == bus.lookup_pc[PC_W-1:2];
      upd_vec[i] = valid_q[i] && tag_q[i] == bus.upd_pc[PC_W-1:2];
      if (hit_vec[i]) begin
        hit_idx    = IDX_W'(i);
        hit_target = target_q[i];
        hit_msb    = ctr_q[i][CTR_W-1];
      end
      if (upd_vec[i]) upd_idx = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end
  assign upd_hit   = |upd_vec;
  assign full      = &valid_q;
  assign alloc_idx = full ? victim_q : free_idx;
  assign bus.pred_hit    = |hit_vec;
  assign bus.pred_taken  = hit_msb;
  assign bus.pred_target = hit_target;
  assign bus.pred_idx    = hit_idx;
  assign bus.occupancy   = occ_q;
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    victim_d = victim_q;
    occ_d    = occ_q;
    if (bus.flush_all) begin
      valid_d  = '0;
      victim_d = '0;
      occ_d    = '0;
    end else if (bus.upd_valid && upd_hit) begin
      ctr_d[upd_idx] = bus.upd_taken
        ? (ctr_q[upd_idx] == CTR_MAX ? CTR_MAX : ctr_q[upd_idx] + 1'b1)
        : (ctr_q[upd_idx] == '0 ? '0 : ctr_q[upd_idx] - 1'b1);
      if (bus.upd_taken) target_d[upd_idx] = bus.upd_target;
    end else if (bus.upd_valid && bus.upd_taken) begin
      valid_d[alloc_idx]  = 1'b1;
      tag_d[alloc_idx]    = bus.upd_pc[PC_W-1:2];
      target_d[alloc_idx] = bus.upd_target;
      ctr_d[alloc_idx]    = CTR_WEAK;
      victim_d            = full ? victim_q + 1'b1 : victim_q;
      occ_d               = full ? occ_q : occ_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: '0};
      victim_q <= '0;
      occ_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      victim_q <= victim_d;
      occ_q    <= occ_d;
    end
  end
endmodule
